reorder_buffer: RTL and testbench

- Circular reorder buffer (ROB) for the out-of-order core; holds in-flight instructions in program order.
- Instructions enter at the tail on push and are marked finished, with a result value, when execution completes.
- The head entry, its value and its ready status are presented continuously for in-order commit; the head retires on pop.

---
 rtl/reorder_buffer.sv | 136 +++++++++++++
 tb/tb_reorder_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular in-order-commit reorder buffer with oldest-match finish.
//            Optional macro ROB_FINISH_BYPASS_EN forwards a head finish to the
//            head outputs combinationally in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] instr_in,
  input  logic             finish_instr,
  input  logic [WIDTH-1:0] instr_to_finish,
  input  logic [WIDTH-1:0] finish_val,
  output logic [WIDTH-1:0] head_instr,
  output logic [WIDTH-1:0] head_val,
  output logic             head_ready,
  output logic             is_full,
  output logic             is_empty
);

  localparam int PTR_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(SIZE + 1);

  logic [WIDTH-1:0] r_instr [SIZE];
  logic [WIDTH-1:0] r_val   [SIZE];
  logic [SIZE-1:0]  r_ready;
  logic [SIZE-1:0]  r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;
  logic             w_fin_hit;
  logic [PTR_W-1:0] w_fin_idx;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(SIZE));
  assign w_do_pop  = pop && !w_empty;
  // A full buffer still accepts a push when the head is leaving in the same cycle.
  assign w_do_push = push && (!w_full || w_do_pop);
  assign is_empty  = w_empty;
  assign is_full   = w_full;

  // Walk from youngest to oldest so the last hit recorded is the oldest match.
  always_comb begin
    int               s;
    logic [PTR_W-1:0] ix;
    s         = 0;
    ix        = '0;
    w_fin_hit = 1'b0;
    w_fin_idx = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      s = int'(r_head) + k;
      if (s >= SIZE) s = s - SIZE;
      ix = PTR_W'(s);
      if (finish_instr && r_valid[ix] && !r_ready[ix] && (r_instr[ix] == instr_to_finish)) begin
        w_fin_hit = 1'b1;
        w_fin_idx = ix;
      end
    end
  end

  // Write order matters: a pop overrides a finish on the same slot, and a push
  // into a slot freed in the same cycle overrides the pop's clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ready <= '0;
      r_valid <= '0;
      for (int i = 0; i < SIZE; i++) begin
        r_instr[i] <= '0;
        r_val[i]   <= '0;
      end
    end else begin
      if (w_fin_hit) begin
        r_val[w_fin_idx]   <= finish_val;
        r_ready[w_fin_idx] <= 1'b1;
      end
      if (w_do_pop) begin
        r_valid[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= f_inc(r_head);
      end
      if (w_do_push) begin
        r_instr[r_tail] <= instr_in;
        r_val[r_tail]   <= '0;
        r_ready[r_tail] <= 1'b0;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= f_inc(r_tail);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_comb begin
    head_instr = '0;
    head_val   = '0;
    head_ready = 1'b0;
    if (!w_empty) begin
      head_instr = r_instr[r_head];
      head_val   = r_val[r_head];
      head_ready = r_ready[r_head];
`ifdef ROB_FINISH_BYPASS_EN
      if (finish_instr && !r_ready[r_head] && (r_instr[r_head] == instr_to_finish)) begin
        head_val   = finish_val;
        head_ready = 1'b1;
      end
`else
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Scoreboard bench for reorder_buffer (SIZE=10, WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;

  localparam int SIZE  = 10;
  localparam int WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] instr_in;
  logic             finish_instr;
  logic [WIDTH-1:0] instr_to_finish;
  logic [WIDTH-1:0] finish_val;
  logic [WIDTH-1:0] head_instr;
  logic [WIDTH-1:0] head_val;
  logic             head_ready;
  logic             is_full;
  logic             is_empty;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] val;
    logic        ready;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  reorder_buffer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .push            (push),
    .pop             (pop),
    .instr_in        (instr_in),
    .finish_instr    (finish_instr),
    .instr_to_finish (instr_to_finish),
    .finish_val      (finish_val),
    .head_instr      (head_instr),
    .head_val        (head_val),
    .head_ready      (head_ready),
    .is_full         (is_full),
    .is_empty        (is_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string ctx);
    logic [31:0] e_instr, e_val;
    logic        e_rdy;
    e_instr = '0;
    e_val   = '0;
    e_rdy   = 1'b0;
    if (q.size() > 0) begin
      e_instr = q[0].instr;
      e_val   = q[0].val;
      e_rdy   = q[0].ready;
    end
    check({ctx, "/empty"},      {31'b0, is_empty},   {31'b0, q.size() == 0});
    check({ctx, "/full"},       {31'b0, is_full},    {31'b0, q.size() == SIZE});
    check({ctx, "/head_instr"}, head_instr,          e_instr);
    check({ctx, "/head_val"},   head_val,            e_val);
    check({ctx, "/head_ready"}, {31'b0, head_ready}, {31'b0, e_rdy});
  endtask

  // One clock: scoreboard compares the retiring head, model updates, then the
  // post-edge head/flags are compared against the model.
  task automatic cycle(input string ctx, input logic p, input logic po, input logic [31:0] din,
                       input logic f, input logic [31:0] fi, input logic [31:0] fv);
    ent_t e;
    bit   done;
    if (po && q.size() > 0) check({ctx, "/pop_instr"}, head_instr, q[0].instr);
    push = p; pop = po; instr_in = din;
    finish_instr = f; instr_to_finish = fi; finish_val = fv;
    done = 1'b0;
    if (f) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!done && !q[i].ready && q[i].instr == fi) begin
          e = q[i]; e.val = fv; e.ready = 1'b1; q[i] = e;
          done = 1'b1;
        end
      end
    end
    if (po && q.size() > 0) void'(q.pop_front());
    if (p && q.size() < SIZE) begin
      e.instr = din; e.val = '0; e.ready = 1'b0;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0; instr_in = '0;
    finish_instr = 1'b0; instr_to_finish = '0; finish_val = '0;
    check_state(ctx);
  endtask

  initial begin
    int pushed;
    logic p, po, f;
    logic [31:0] fi;
    reset = 1'b0; push = 1'b0; pop = 1'b0; instr_in = '0;
    finish_instr = 1'b0; instr_to_finish = '0; finish_val = '0;
    repeat (2) @(posedge clock);
    #1;
    check_state("reset");
    reset = 1'b1;
    @(posedge clock); #1;
    check_state("idle");

    cycle("push1", 1, 0, 32'h1, 0, 0, 0);
    cycle("push2", 1, 0, 32'h2, 0, 0, 0);
    cycle("fin2",  0, 0, 0, 1, 32'h2, 32'hDEADBEEF);
    cycle("fin1",  0, 0, 0, 1, 32'h1, 32'h12345678);
    check("fin1/val_lit", head_val, 32'h12345678);
    cycle("pop1",  0, 1, 0, 0, 0, 0);
    check("pop1/val_lit", head_val, 32'hDEADBEEF);
    cycle("pop2",  0, 1, 0, 0, 0, 0);

    for (int i = 0; i < SIZE; i++) cycle("fill", 1, 0, 32'h10 + i, 0, 0, 0);
    check("fill/full_lit", {31'b0, is_full}, 32'd1);
    cycle("push_full", 1, 0, 32'h1A, 0, 0, 0);
    cycle("push_pop_full", 1, 1, 32'h1A, 0, 0, 0);
    check("push_pop_full/head_lit", head_instr, 32'h11);
    for (int i = 0; i < SIZE; i++) cycle("drain", 0, 1, 0, 0, 0, 0);
    cycle("pop_empty", 0, 1, 0, 0, 0, 0);

    pushed = 0;
    for (int c = 0; c < 400 && (pushed < 25 || q.size() > 0); c++) begin
      p  = (pushed < 25) && ($urandom_range(0, 2) != 0);
      po = ($urandom_range(0, 1) == 1);
      f  = ($urandom_range(0, 1) == 1);
      fi = 32'h100 + $urandom_range(0, 24);
      if (p && (q.size() < SIZE || (po && q.size() > 0))) begin
        cycle("wrap", p, po, 32'h100 + pushed, f, fi, $urandom);
        pushed++;
      end else begin
        cycle("wrap", 1'b0, po, 0, f, fi, $urandom);
      end
    end
    check("wrap/all_pushed", pushed, 25);
    check("wrap/end_empty", {31'b0, is_empty}, 32'd1);
    cycle("pop_empty2", 0, 1, 0, 0, 0, 0);

    cycle("push_fin_same", 1, 0, 32'h77, 1, 32'h77, 32'h9);
    cycle("fin_pop_same", 0, 1, 0, 1, 32'h77, 32'h9);

    cycle("dup_a", 1, 0, 32'h5, 0, 0, 0);
    cycle("dup_b", 1, 0, 32'h5, 0, 0, 0);
    cycle("dup_fin", 0, 0, 0, 1, 32'h5, 32'hA);
    check("dup_fin/val_lit", head_val, 32'hA);
    cycle("dup_pop", 0, 1, 0, 0, 0, 0);
    check("dup_pop/second_not_ready", {31'b0, head_ready}, 32'd0);
    cycle("pre_rst", 1, 0, 32'h6, 0, 0, 0);

    #2 reset = 1'b0;
    q.delete();
    #1 check_state("async_rst");
    #2 reset = 1'b1;
    cycle("post_rst", 1, 0, 32'h33, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
